seq_detect_param: RTL and testbench

- Registered, parametrised serial sequence detector; successor to the fixed 2-bit state-transition function.
- Detects a runtime-programmable N-bit pattern on a qualified serial bit stream, with selectable overlapping or non-overlapping detection.
- Emits a one-cycle match pulse and keeps a saturating match count.
- Sits after the serial input synchroniser and feeds the control FSMs in the assignment designs.

---
 rtl/seqdet_pkg.sv | 14 +
 rtl/seqdet_next.sv | 40 ++++
 rtl/seq_detect_param.sv | 86 ++++++++
 tb/tb_seq_detect_param.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// Shared constants and helpers for the parametrised sequence detector.
// Mode encodings, default pattern, and fill-counter width function.
package seqdet_pkg;

  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  localparam logic [3:0] SEQDET_DEF_PAT = 4'b1011;

  function automatic int fill_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seqdet_next.sv
// Combinational next-state for the sequence detector history.
// Shifts in one bit, advances fill, and flags a pattern hit.
module seqdet_next
  import seqdet_pkg::*;
#(
  parameter int N  = 4,
  parameter int FW = 3
) (
  input  logic [N-1:0]  hist,
  input  logic [FW-1:0] fill,
  input  logic          in_bit,
  input  logic [N-1:0]  pattern,
  input  logic          overlap,
  output logic [N-1:0]  hist_nx,
  output logic [FW-1:0] fill_nx,
  output logic          hit
);

  localparam logic [FW:0] NFULL = (FW+1)'(N);
  localparam logic [FW:0] ONE   = (FW+1)'(1);

  logic [FW:0] inc;
  logic [FW:0] sat;
  logic        unused_msb;

  assign unused_msb = hist[N-1];

  // shift, saturate fill at N, and clear fill after a non-overlapping hit
  always_comb begin
    hist_nx = {hist[N-2:0], in_bit};
    inc     = {1'b0, fill} + ONE;
    sat     = (inc > NFULL) ? NFULL : inc;
    hit     = (sat == NFULL) && (hist_nx == pattern);
    fill_nx = sat[FW-1:0];
    if (hit && (overlap == MODE_NONOVL)) begin
      fill_nx = '0;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Registered serial sequence detector with programmable N-bit pattern.
// Optional saturating match counter built when SEQDET_COUNT_EN is defined.
module seq_detect_param
  import seqdet_pkg::*;
#(
  parameter int          N           = 4,
  parameter logic [N-1:0] DEF_PATTERN = SEQDET_DEF_PAT,
  parameter int          CW          = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_bit,
  input  logic                    pat_load,
  input  logic [N-1:0]            pat_in,
  input  logic                    overlap,
  output logic                    match,
  output logic [CW-1:0]           match_count,
  output logic [fill_w(N)-1:0]    fill
);

  localparam int FW = fill_w(N);

  logic [N-1:0]  pattern;
  logic [N-1:0]  hist;
  logic [N-1:0]  hist_nx;
  logic [FW-1:0] fill_nx;
  logic          hit;
  logic          accept;

  assign accept = in_valid && !pat_load;

  seqdet_next #(
    .N  (N),
    .FW (FW)
  ) u_next (
    .hist    (hist),
    .fill    (fill),
    .in_bit  (in_bit),
    .pattern (pattern),
    .overlap (overlap),
    .hist_nx (hist_nx),
    .fill_nx (fill_nx),
    .hit     (hit)
  );

  // pattern/history/fill/match registers; a pattern load wins over data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern <= DEF_PATTERN;
      hist    <= '0;
      fill    <= '0;
      match   <= 1'b0;
    end else if (pat_load) begin
      pattern <= pat_in;
      fill    <= '0;
      match   <= 1'b0;
    end else if (in_valid) begin
      hist    <= hist_nx;
      fill    <= fill_nx;
      match   <= hit;
    end else begin
      match   <= 1'b0;
    end
  end

`ifdef SEQDET_COUNT_EN
  logic [CW-1:0] cnt;

  // saturating hit counter, cleared by a pattern load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (pat_load) begin
      cnt <= '0;
    end else if (accept && hit && (cnt != '1)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign match_count = cnt;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param.
// Expected counts follow whether SEQDET_COUNT_EN is defined.
module tb_seq_detect_param;

`ifdef SEQDET_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       overlap;

  logic       match;
  logic [7:0] cnt;
  logic [2:0] fill;
  logic       match_s;
  logic [1:0] cnt_s;
  logic [2:0] fill_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.N(4), .DEF_PATTERN(4'b1011), .CW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .pat_load    (pat_load),
    .pat_in      (pat_in),
    .overlap     (overlap),
    .match       (match),
    .match_count (cnt),
    .fill        (fill)
  );

  seq_detect_param #(.N(4), .DEF_PATTERN(4'b1011), .CW(2)) dut_s (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .pat_load    (pat_load),
    .pat_in      (pat_in),
    .overlap     (overlap),
    .match       (match_s),
    .match_count (cnt_s),
    .fill        (fill_s)
  );

  function automatic int cexp(int n, int cw);
    int mx;
    mx = (1 << cw) - 1;
    if (!CNT_EN) return 0;
    return (n > mx) ? mx : n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(logic b);
    in_valid = 1'b1;
    in_bit   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic load(logic [3:0] p);
    pat_load = 1'b1;
    pat_in   = p;
    @(posedge clk);
    #1;
    pat_load = 1'b0;
  endtask

  logic [6:0] s7;
  logic [6:0] m7;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    pat_load = 1'b0;
    pat_in   = 4'b0000;
    overlap  = 1'b1;
    #2;
    chk("rst_match", match, 0);
    chk("rst_fill", fill, 0);
    chk("rst_cnt", cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // overlapping, default pattern
    s7 = 7'b1011011;
    m7 = 7'b0001001;
    overlap = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(s7[6-i]);
      chk($sformatf("ovl_match%0d", i), match, m7[6-i]);
    end
    chk("ovl_cnt", cnt, cexp(2, 8));
    chk("ovl_fill", fill, 4);

    // non-overlapping
    load(4'b1011);
    chk("ld_fill", fill, 0);
    chk("ld_cnt", cnt, 0);
    overlap = 1'b0;
    m7 = 7'b0001000;
    for (int i = 0; i < 7; i++) begin
      send(s7[6-i]);
      chk($sformatf("novl_match%0d", i), match, m7[6-i]);
    end
    chk("novl_cnt", cnt, cexp(1, 8));
    chk("novl_fill", fill, 3);

    // valid gaps
    load(4'b1011);
    overlap = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(s7[6-i]);
      chk($sformatf("gap_match%0d", i), match, (i == 3) ? 1 : 0);
      for (int j = 0; j < 3; j++) begin
        idle();
        chk($sformatf("gap_idle%0d_%0d", i, j), match, 0);
        chk($sformatf("gap_fill%0d_%0d", i, j), fill, i + 1);
      end
    end
    chk("gap_cnt", cnt, cexp(1, 8));

    // reload mid-stream drops the coincident bit
    load(4'b1011);
    send(1'b1);
    send(1'b0);
    send(1'b1);
    chk("rl_pre_fill", fill, 3);
    pat_load = 1'b1;
    pat_in   = 4'b0110;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(posedge clk);
    #1;
    pat_load = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    chk("rl_fill", fill, 0);
    chk("rl_cnt", cnt, 0);
    chk("rl_match", match, 0);
    send(1'b0);
    chk("rl_m0", match, 0);
    send(1'b1);
    chk("rl_m1", match, 0);
    send(1'b1);
    chk("rl_m2", match, 0);
    send(1'b0);
    chk("rl_m3", match, 1);
    chk("rl_cnt2", cnt, cexp(1, 8));

    // saturation on the 2-bit counter instance
    load(4'b1111);
    overlap = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(1'b1);
      chk($sformatf("sat_match%0d", i), match_s, (i >= 3) ? 1 : 0);
      chk($sformatf("sat_cnt%0d", i), cnt_s,
          cexp((i >= 3) ? i - 2 : 0, 2));
    end
    chk("sat_cnt_wide", cnt, cexp(5, 8));

    // async reset mid-stream
    send(1'b1);
    send(1'b0);
    send(1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_match", match, 0);
    chk("ar_fill", fill, 0);
    chk("ar_cnt", cnt, 0);
    chk("ar_cnt_s", cnt_s, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(1'b1);
    chk("ar_m_first", match, 0);
    chk("ar_fill1", fill, 1);
    send(1'b0);
    send(1'b1);
    send(1'b1);
    chk("ar_defpat", match, 1);
    chk("ar_cnt_end", cnt, cexp(1, 8));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
